// File: rtl/multicycle_controller.sv
// Moore multicycle control FSM for the 32-bit RISC core: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects and write enables, with parametrised memory latency and stall support.
module multicycle_controller #(
    parameter int unsigned MEM_LAT    = 1,
    parameter bit          ENABLE_JAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       stall,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_JALEX   = 4'd12
    } state_t;

    localparam int unsigned CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    state_t        cur;
    state_t        nxt;
    logic [CW-1:0] wait_cnt;
    logic          last;
    logic          rtype_ok;
    logic          op_ok;
    logic          pcwrite;
    logic          branch;
    logic          irw;
    logic          rw;
    logic          mw;
    logic          hold;

    assign last  = (wait_cnt == LAST);
    assign state = cur;
    assign hold  = rst | stall;

    always_comb begin
        rtype_ok = 1'b0;
        case (funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: rtype_ok = 1'b1;
            default: rtype_ok = 1'b0;
        endcase
        op_ok = 1'b0;
        case (op)
            6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: op_ok = 1'b1;
            6'b000000: op_ok = rtype_ok;
            6'b000011: op_ok = ENABLE_JAL;
            default:   op_ok = 1'b0;
        endcase
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = last ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!op_ok) nxt = S_FETCH;
                else begin
                    case (op)
                        6'b100011, 6'b101011: nxt = S_MEMADR;
                        6'b000000:            nxt = S_RTYPEEX;
                        6'b000100:            nxt = S_BEQEX;
                        6'b001000:            nxt = S_ADDIEX;
                        6'b000010:            nxt = S_JEX;
                        6'b000011:            nxt = S_JALEX;
                        default:              nxt = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  nxt = (op == 6'b101011) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   nxt = last ? S_MEMWB : S_MEMRD;
            S_MEMWB:   nxt = S_FETCH;
            S_MEMWR:   nxt = last ? S_FETCH : S_MEMWR;
            S_RTYPEEX: nxt = S_RTYPEWB;
            S_RTYPEWB: nxt = S_FETCH;
            S_BEQEX:   nxt = S_FETCH;
            S_ADDIEX:  nxt = S_ADDIWB;
            S_ADDIWB:  nxt = S_FETCH;
            S_JEX:     nxt = S_FETCH;
            S_JALEX:   nxt = S_FETCH;
            default:   nxt = S_FETCH;
        endcase
    end

    // Every state change clears the counter, so memory states always start counting from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
        end else if (!stall) begin
            cur <= nxt;
            if (nxt != cur) wait_cnt <= '0;
            else            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irw        = 1'b0;
        rw         = 1'b0;
        mw         = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        alucontrol = 3'b010;
        illegal_op = 1'b0;
        case (cur)
            S_FETCH: begin
                alusrcb = 2'b01;
                irw     = last;
                pcwrite = last;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = ~op_ok;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 2'b01;
                rw       = 1'b1;
            end
            S_MEMWR: begin
                iord = 1'b1;
                mw   = last;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            S_RTYPEWB: begin
                regdst = 2'b01;
                rw     = 1'b1;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                branch     = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: rw = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            S_JALEX: begin
                pcsrc    = 2'b10;
                pcwrite  = 1'b1;
                regdst   = 2'b10;
                memtoreg = 2'b10;
                rw       = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcen     = (pcwrite | (branch & zero)) & ~hold;
    assign irwrite  = irw & ~hold;
    assign regwrite = rw & ~hold;
    assign memwrite = mw & ~hold;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst, rst3;
    logic [5:0] op, op3, funct;
    logic       zero, stall, stall3;

    logic       pcen, irwrite, regwrite, memwrite, iord, alusrca, illegal_op;
    logic [1:0] alusrcb, pcsrc, regdst, memtoreg;
    logic [2:0] alucontrol;
    logic [3:0] state;

    logic       pcen3, irwrite3, regwrite3, memwrite3, iord3, alusrca3, illegal3;
    logic [1:0] alusrcb3, pcsrc3, regdst3, memtoreg3;
    logic [2:0] alucontrol3;
    logic [3:0] state3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_LAT(1), .ENABLE_JAL(1'b1)) u1 (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .stall(stall),
        .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .regdst(regdst), .memtoreg(memtoreg), .alucontrol(alucontrol),
        .illegal_op(illegal_op), .state(state)
    );

    multicycle_controller #(.MEM_LAT(3), .ENABLE_JAL(1'b1)) u3 (
        .clk(clk), .rst(rst3), .op(op3), .funct(funct), .zero(zero), .stall(stall3),
        .pcen(pcen3), .irwrite(irwrite3), .regwrite(regwrite3), .memwrite(memwrite3),
        .iord(iord3), .alusrca(alusrca3), .alusrcb(alusrcb3), .pcsrc(pcsrc3),
        .regdst(regdst3), .memtoreg(memtoreg3), .alucontrol(alucontrol3),
        .illegal_op(illegal3), .state(state3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst3 = 1'b1; op = 6'b100011; op3 = 6'b101011;
        funct = 6'b100000; zero = 1'b0; stall = 1'b0; stall3 = 1'b0;
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_irwrite", 32'(irwrite), 32'd0);
        check("rst_pcen", 32'(pcen), 32'd0);

        // lw, interrupted by reset while in MEMRD
        rst = 1'b0; #1;
        check("fetch_irwrite", 32'(irwrite), 32'd1);
        check("fetch_pcen", 32'(pcen), 32'd1);
        check("fetch_alusrcb", 32'(alusrcb), 32'd1);
        tick(); check("lw_s1", 32'(state), 32'd1);
        check("lw_dec_alusrcb", 32'(alusrcb), 32'd3);
        tick(); check("lw_s2", 32'(state), 32'd2);
        check("lw_memadr_b", 32'(alusrcb), 32'd2);
        tick(); check("lw_s3", 32'(state), 32'd3);
        check("lw_memrd_iord", 32'(iord), 32'd1);
        rst = 1'b1; #1;
        check("rst_mid_regwrite", 32'(regwrite), 32'd0);
        tick(); check("rst_mid_s0a", 32'(state), 32'd0);
        check("rst_mid_rw_a", 32'(regwrite), 32'd0);
        tick(); check("rst_mid_s0b", 32'(state), 32'd0);
        rst = 1'b0; #1;
        check("post_rst_irwrite", 32'(irwrite), 32'd1);
        check("post_rst_pcen", 32'(pcen), 32'd1);

        // full lw: 0,1,2,3,4,0
        tick(); check("lw2_s1", 32'(state), 32'd1);
        check("lw2_s1_rw", 32'(regwrite), 32'd0);
        tick(); check("lw2_s2", 32'(state), 32'd2);
        tick(); check("lw2_s3", 32'(state), 32'd3);
        check("lw2_s3_rw", 32'(regwrite), 32'd0);
        tick(); check("lw2_s4", 32'(state), 32'd4);
        check("lw2_wb_rw", 32'(regwrite), 32'd1);
        check("lw2_wb_m2r", 32'(memtoreg), 32'd1);
        check("lw2_wb_rdst", 32'(regdst), 32'd0);
        tick(); check("lw2_s0", 32'(state), 32'd0);
        check("lw2_s0_rw", 32'(regwrite), 32'd0);

        // R-type sub with stall in RTYPEWB
        op = 6'b000000; funct = 6'b100010;
        tick(); check("r_s1", 32'(state), 32'd1);
        check("r_dec_legal", 32'(illegal_op), 32'd0);
        tick(); check("r_s6", 32'(state), 32'd6);
        check("r_sub_alu", 32'(alucontrol), 32'd6);
        check("r_alusrca", 32'(alusrca), 32'd1);
        tick(); check("r_s7", 32'(state), 32'd7);
        stall = 1'b1; #1;
        check("stall_rw0", 32'(regwrite), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", 32'(state), 32'd7);
            check("stall_rw", 32'(regwrite), 32'd0);
        end
        tick(); check("stall_hold4", 32'(state), 32'd7);
        stall = 1'b0; #1;
        check("unstall_rw", 32'(regwrite), 32'd1);
        check("unstall_rdst", 32'(regdst), 32'd1);
        tick(); check("unstall_s0", 32'(state), 32'd0);

        // illegal funct
        funct = 6'b000100;
        tick(); check("ill_s1", 32'(state), 32'd1);
        check("ill_flag", 32'(illegal_op), 32'd1);
        check("ill_rw", 32'(regwrite), 32'd0);
        tick(); check("ill_s0", 32'(state), 32'd0);

        // beq
        op = 6'b000100; funct = 6'b100000; zero = 1'b1;
        tick(); tick(); check("beq_s8", 32'(state), 32'd8);
        check("beq_pcen1", 32'(pcen), 32'd1);
        check("beq_pcsrc", 32'(pcsrc), 32'd1);
        check("beq_sub", 32'(alucontrol), 32'd6);
        zero = 1'b0; #1;
        check("beq_pcen0", 32'(pcen), 32'd0);
        tick(); check("beq_s0", 32'(state), 32'd0);

        // jal
        op = 6'b000011;
        tick(); tick(); check("jal_s12", 32'(state), 32'd12);
        check("jal_rdst", 32'(regdst), 32'd2);
        check("jal_m2r", 32'(memtoreg), 32'd2);
        check("jal_pcen", 32'(pcen), 32'd1);
        check("jal_pcsrc", 32'(pcsrc), 32'd2);
        tick(); check("jal_s0", 32'(state), 32'd0);

        // addi
        op = 6'b001000;
        tick(); tick(); check("addi_s9", 32'(state), 32'd9);
        check("addi_b", 32'(alusrcb), 32'd2);
        tick(); check("addi_s10", 32'(state), 32'd10);
        check("addi_rw", 32'(regwrite), 32'd1);
        tick(); check("addi_s0", 32'(state), 32'd0);

        // sw at MEM_LAT=3
        rst3 = 1'b0; #1;
        check("sw3_f0_irw", 32'(irwrite3), 32'd0);
        tick(); check("sw3_f1_s", 32'(state3), 32'd0);
        check("sw3_f1_irw", 32'(irwrite3), 32'd0);
        tick(); check("sw3_f2_s", 32'(state3), 32'd0);
        check("sw3_f2_irw", 32'(irwrite3), 32'd1);
        check("sw3_f2_pcen", 32'(pcen3), 32'd1);
        tick(); check("sw3_s1", 32'(state3), 32'd1);
        tick(); check("sw3_s2", 32'(state3), 32'd2);
        tick(); check("sw3_w0_s", 32'(state3), 32'd5);
        check("sw3_w0_mw", 32'(memwrite3), 32'd0);
        check("sw3_iord", 32'(iord3), 32'd1);
        tick(); check("sw3_w1_s", 32'(state3), 32'd5);
        check("sw3_w1_mw", 32'(memwrite3), 32'd0);
        tick(); check("sw3_w2_s", 32'(state3), 32'd5);
        check("sw3_w2_mw", 32'(memwrite3), 32'd1);
        tick(); check("sw3_s0", 32'(state3), 32'd0);
        check("sw3_s0_mw", 32'(memwrite3), 32'd0);
        check("sw3_s0_irw", 32'(irwrite3), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
